// File: rtl/mips_lite_pkg.sv
// mips_lite_pkg: shared register-file widths and index/data types.
package mips_lite_pkg;
    localparam int REG_AW   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    typedef logic [REG_AW-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy bits for results still owed by the long-latency unit.
//   clk, reset_n             clock, async active-low reset
//   set_i / set_idx_i        mark a register busy (new long op issued)
//   clr_i / clr_idx_i        mark a register free (long result committed)
//   rd0/1/2_idx_i            three lookup indices
//   rd_busy_o                busy bit for each lookup, bit k for rdk_idx_i
module rf_scoreboard
    import mips_lite_pkg::*;
#(
    parameter int NREGS = NUM_REGS,
    parameter int AW    = REG_AW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          set_i,
    input  logic [AW-1:0] set_idx_i,
    input  logic          clr_i,
    input  logic [AW-1:0] clr_idx_i,
    input  logic [AW-1:0] rd0_idx_i,
    input  logic [AW-1:0] rd1_idx_i,
    input  logic [AW-1:0] rd2_idx_i,
    output logic [2:0]    rd_busy_o
);
    logic [NREGS-1:0] busy_q, busy_d, set_mask, clr_mask;

    // Set is applied after clear so a same-cycle set/clear leaves the new op outstanding;
    // r0 never holds a pending result.
    always_comb begin
        set_mask  = set_i ? (NREGS'(1) << set_idx_i) : '0;
        clr_mask  = clr_i ? (NREGS'(1) << clr_idx_i) : '0;
        busy_d    = (busy_q & ~clr_mask) | set_mask;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) busy_q <= '0;
        else          busy_q <= busy_d;

    assign rd_busy_o = {busy_q[rd2_idx_i], busy_q[rd1_idx_i], busy_q[rd0_idx_i]};
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: owns the register-file write port, arbitrating pipeline writeback (A)
// against the long-latency unit (B), with a busy scoreboard and anti-starvation stall.
//   clk, reset_n                       clock, async active-low reset
//   a_we, a_rd, a_wd                   pipeline writeback (fixed priority, no back-pressure)
//   b_valid, b_rd, b_wd, b_ready       long-latency result handshake
//   iss_valid, iss_long, iss_rs1/rs2/rd, iss_fire   issue-stage lookup and issue event
//   hazard_stall                       issue operand/destination still owed by B
//   pipe_stall_req                     pipeline must hold A idle so B can drain
//   rf_we, rf_rd, rf_wd                register-file write port
module rf_wb_arbiter
    import mips_lite_pkg::*;
#(
    parameter int NREGS    = NUM_REGS,
    parameter int AW       = REG_AW,
    parameter int DW       = DATA_W,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          a_we,
    input  logic [AW-1:0] a_rd,
    input  logic [DW-1:0] a_wd,
    input  logic          b_valid,
    input  logic [AW-1:0] b_rd,
    input  logic [DW-1:0] b_wd,
    output logic          b_ready,
    input  logic          iss_valid,
    input  logic          iss_long,
    input  logic [AW-1:0] iss_rs1,
    input  logic [AW-1:0] iss_rs2,
    input  logic [AW-1:0] iss_rd,
    input  logic          iss_fire,
    output logic          hazard_stall,
    output logic          pipe_stall_req,
    output logic          rf_we,
    output logic [AW-1:0] rf_rd,
    output logic [DW-1:0] rf_wd
);
    localparam int WCW = $clog2(MAX_WAIT + 1);

    logic           a_act, b_acc;
    logic [2:0]     rd_busy;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic           psr_q, psr_d;

    // A write to r0 is a no-op, so it does not consume the port.
    assign a_act   = a_we && a_rd != '0;
    assign b_ready = reset_n && b_valid && !a_act;
    assign b_acc   = b_valid && b_ready;

    assign rf_we = reset_n && (a_act || (b_acc && b_rd != '0));
    assign rf_rd = !reset_n ? '0 : a_act ? a_rd : b_valid ? b_rd : '0;
    assign rf_wd = !reset_n ? '0 : a_act ? a_wd : b_valid ? b_wd : '0;

    rf_scoreboard #(.NREGS(NREGS), .AW(AW)) u_sb (
        .clk       (clk),
        .reset_n   (reset_n),
        .set_i     (iss_fire && iss_long),
        .set_idx_i (iss_rd),
        .clr_i     (b_acc),
        .clr_idx_i (b_rd),
        .rd0_idx_i (iss_rs1),
        .rd1_idx_i (iss_rs2),
        .rd2_idx_i (iss_rd),
        .rd_busy_o (rd_busy)
    );

    assign hazard_stall = reset_n && iss_valid && |rd_busy;

    // The stall request is held until B is actually accepted, not merely until wcnt drops.
    always_comb begin
        wcnt_d = (b_valid && !b_ready) ? (wcnt_q == WCW'(MAX_WAIT) ? wcnt_q : wcnt_q + WCW'(1)) : '0;
        psr_d  = b_acc ? 1'b0 : (wcnt_d >= WCW'(MAX_WAIT)) ? 1'b1 : psr_q;
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            wcnt_q <= '0;
            psr_q  <= 1'b0;
        end else begin
            wcnt_q <= wcnt_d;
            psr_q  <= psr_d;
        end

    assign pipe_stall_req = psr_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_rf_wb_arbiter;
    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0, reset_n = 1'b0;
    logic        a_we = 0, b_valid = 0, iss_valid = 0, iss_long = 0, iss_fire = 0;
    logic [4:0]  a_rd = 0, b_rd = 0, iss_rs1 = 0, iss_rs2 = 0, iss_rd = 0;
    logic [31:0] a_wd = 0, b_wd = 0;
    logic        b_ready, hazard_stall, pipe_stall_req, rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wd;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_we(a_we), .a_rd(a_rd), .a_wd(a_wd),
        .b_valid(b_valid), .b_rd(b_rd), .b_wd(b_wd), .b_ready(b_ready),
        .iss_valid(iss_valid), .iss_long(iss_long), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
        .iss_rd(iss_rd), .iss_fire(iss_fire), .hazard_stall(hazard_stall),
        .pipe_stall_req(pipe_stall_req), .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd)
    );

    int checks = 0, errors = 0;

    // Behavioural model: set of registers owed by B, length of the current blocked run of B,
    // and the stall-request flag.
    bit [31:0] m_busy;
    int        m_run;
    bit        m_psr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic e_aact();
        return a_we && a_rd != 0;
    endfunction
    function automatic logic e_bready();
        return reset_n && b_valid && !e_aact();
    endfunction
    function automatic logic e_we();
        return reset_n && (e_aact() || (e_bready() && b_rd != 0));
    endfunction
    function automatic logic [4:0] e_rd();
        return !reset_n ? 5'd0 : e_aact() ? a_rd : b_valid ? b_rd : 5'd0;
    endfunction
    function automatic logic [31:0] e_wd();
        return !reset_n ? 32'd0 : e_aact() ? a_wd : b_valid ? b_wd : 32'd0;
    endfunction
    function automatic logic e_haz();
        return reset_n && iss_valid && (m_busy[iss_rs1] || m_busy[iss_rs2] || m_busy[iss_rd]);
    endfunction

    always @(posedge clk or negedge reset_n) begin : model
        bit acc;
        if (!reset_n) begin
            m_busy = 0;
            m_run  = 0;
            m_psr  = 0;
        end else begin
            acc = e_bready();
            if (acc) m_busy[b_rd] = 1'b0;
            if (iss_fire && iss_long && iss_rd != 0) m_busy[iss_rd] = 1'b1;
            m_run = (b_valid && !acc) ? m_run + 1 : 0;
            if (acc) m_psr = 1'b0;
            else if (m_run >= MAX_WAIT) m_psr = 1'b1;
        end
    end

    always @(negedge clk) begin
        chk("b_ready", 32'(b_ready), 32'(e_bready()));
        chk("rf_we", 32'(rf_we), 32'(e_we()));
        chk("rf_rd", 32'(rf_rd), 32'(e_rd()));
        chk("rf_wd", rf_wd, e_wd());
        chk("hazard_stall", 32'(hazard_stall), 32'(e_haz()));
        chk("pipe_stall_req", 32'(pipe_stall_req), 32'(m_psr));
    end

    // While the stall request is up, the pipeline must not present a live writeback.
    always @(posedge clk)
        if (reset_n && pipe_stall_req)
            assert (!(a_we && a_rd != 0)) else begin
                errors++;
                $display("FAIL stall_rule a_act=1 while pipe_stall_req=1 at %0t", $time);
            end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        a_we = 0; a_rd = 0; a_wd = 0; b_valid = 0; b_rd = 0; b_wd = 0;
        iss_valid = 0; iss_long = 0; iss_fire = 0; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0;
    endtask

    initial begin
        bit hold, last_acc, do_rst;
        // Reset state with live requests on every input.
        a_we = 1; a_rd = 5; a_wd = 32'h1111_1111; b_valid = 1; b_rd = 6; iss_valid = 1;
        #3;
        chk("rst_rf_we", 32'(rf_we), 0);
        chk("rst_b_ready", 32'(b_ready), 0);
        chk("rst_rf_rd", 32'(rf_rd), 0);
        chk("rst_rf_wd", rf_wd, 0);
        chk("rst_psr", 32'(pipe_stall_req), 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        clr_inputs();
        nxt();

        // A vs B conflict, then B drains.
        a_we = 1; a_rd = 3; a_wd = 32'hDEAD_BEEF; b_valid = 1; b_rd = 7; b_wd = 32'h1234_5678;
        @(negedge clk);
        chk("t2_c0_we", 32'(rf_we), 1);
        chk("t2_c0_rd", 32'(rf_rd), 3);
        chk("t2_c0_wd", rf_wd, 32'hDEAD_BEEF);
        chk("t2_c0_bready", 32'(b_ready), 0);
        nxt(); a_we = 0;
        @(negedge clk);
        chk("t2_c1_rd", 32'(rf_rd), 7);
        chk("t2_c1_wd", rf_wd, 32'h1234_5678);
        chk("t2_c1_bready", 32'(b_ready), 1);
        nxt(); clr_inputs();

        // RAW hazard until B commits r9.
        iss_valid = 1; iss_long = 1; iss_rd = 9; iss_fire = 1;
        @(negedge clk); chk("t3_issue_haz", 32'(hazard_stall), 0);
        nxt(); iss_fire = 0; iss_long = 0; iss_rd = 0; iss_rs1 = 9;
        @(negedge clk); chk("t3_raw_haz", 32'(hazard_stall), 1);
        nxt(); b_valid = 1; b_rd = 9; b_wd = 32'h0000_0009;
        @(negedge clk); chk("t3_commit_haz", 32'(hazard_stall), 1); chk("t3_commit_rd", 32'(rf_rd), 9);
        nxt(); b_valid = 0;
        @(negedge clk); chk("t3_after_haz", 32'(hazard_stall), 0);
        nxt(); clr_inputs();

        // Same-cycle clear and set of r4.
        iss_valid = 1; iss_long = 1; iss_rd = 4; iss_fire = 1;
        nxt(); b_valid = 1; b_rd = 4;
        @(negedge clk); chk("t4_bready", 32'(b_ready), 1);
        nxt(); b_valid = 0; iss_fire = 0; iss_long = 0; iss_rd = 0; iss_rs2 = 4;
        @(negedge clk); chk("t4_busy_kept", 32'(hazard_stall), 1);
        nxt(); b_valid = 1; b_rd = 4;
        nxt(); b_valid = 0;
        @(negedge clk); chk("t4_cleared", 32'(hazard_stall), 0);
        nxt(); clr_inputs();

        // Starvation of B under continuous A traffic.
        a_we = 1; a_rd = 1; a_wd = 32'hA5A5_0001; b_valid = 1; b_rd = 6; b_wd = 32'h0000_0066;
        for (int i = 0; i < MAX_WAIT; i++) begin
            @(negedge clk); chk("t5_psr_low", 32'(pipe_stall_req), 0);
            nxt();
        end
        a_we = 0;
        @(negedge clk);
        chk("t5_psr_high", 32'(pipe_stall_req), 1);
        chk("t5_b_granted", 32'(b_ready), 1);
        chk("t5_b_rd", 32'(rf_rd), 6);
        nxt(); b_valid = 0;
        @(negedge clk); chk("t5_psr_cleared", 32'(pipe_stall_req), 0);
        nxt(); clr_inputs();

        // r0 handling and asynchronous reset with r2 busy.
        a_we = 1; a_rd = 0; a_wd = 32'hFFFF_FFFF; b_valid = 1; b_rd = 2; b_wd = 32'hCAFE_0002;
        @(negedge clk);
        chk("t6_a_r0_bready", 32'(b_ready), 1);
        chk("t6_a_r0_we", 32'(rf_we), 1);
        chk("t6_a_r0_rd", 32'(rf_rd), 2);
        chk("t6_a_r0_wd", rf_wd, 32'hCAFE_0002);
        nxt(); a_we = 0; b_rd = 0;
        @(negedge clk);
        chk("t6_b_r0_bready", 32'(b_ready), 1);
        chk("t6_b_r0_we", 32'(rf_we), 0);
        nxt(); b_valid = 0; iss_valid = 1; iss_long = 1; iss_fire = 1; iss_rd = 2;
        nxt(); iss_fire = 0; iss_long = 0; iss_rd = 0; iss_rs1 = 2;
        a_we = 1; a_rd = 5; a_wd = 32'h5555_5555; b_valid = 1; b_rd = 3;
        #1 chk("t6_pre_rst_haz", 32'(hazard_stall), 1);
        #1 reset_n = 0;
        #1;
        chk("t6_rst_we", 32'(rf_we), 0);
        chk("t6_rst_bready", 32'(b_ready), 0);
        chk("t6_rst_haz", 32'(hazard_stall), 0);
        chk("t6_rst_rd", 32'(rf_rd), 0);
        chk("t6_rst_wd", rf_wd, 0);
        nxt(); reset_n = 1; b_valid = 0;
        @(negedge clk);
        chk("t6_busy_gone", 32'(hazard_stall), 0);
        chk("t6_post_rd", 32'(rf_rd), 5);
        nxt(); clr_inputs();

        // Randomized traffic; B holds its result until accepted, issue respects hazards.
        last_acc = 0;
        for (int c = 0; c < 3000; c++) begin
            hold = b_valid && !last_acc;
            if (!reset_n) begin
                reset_n = 1;
                hold = 0;
            end
            a_we = m_psr ? 1'b0 : ($urandom_range(0, 9) < 7);
            a_rd = 5'($urandom_range(0, 7));
            a_wd = $urandom;
            if (!hold) begin
                b_valid = ($urandom_range(0, 9) < 4);
                b_rd = 5'($urandom_range(0, 7));
                b_wd = $urandom;
            end
            iss_valid = ($urandom_range(0, 9) < 6);
            iss_long = $urandom_range(0, 1) == 1;
            iss_rs1 = 5'($urandom_range(0, 7));
            iss_rs2 = 5'($urandom_range(0, 7));
            iss_rd = 5'($urandom_range(0, 7));
            iss_fire = iss_valid && !(m_busy[iss_rs1] || m_busy[iss_rs2] || m_busy[iss_rd])
                       && ($urandom_range(0, 9) < 8);
            last_acc = b_valid && !(a_we && a_rd != 0);
            do_rst = $urandom_range(0, 499) == 0;
            if (do_rst) begin
                #1 reset_n = 0;
                b_valid = 0;
            end
            nxt();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
